// File: rtl/vga_parpadeo_ctrl.sv
// Alarm flash sequencer and programming-cursor blink mask for the VGA clock display.
// Define ALARMA_SONIDO_EN to build the buzzer tone generator; otherwise zumbador is tied low.
module vga_parpadeo_ctrl #(
  parameter logic [23:0] CUENTA          = 24'd16666666,
  parameter logic [5:0]  TOTAL_PARPADEOS = 6'd30,
  parameter logic [24:0] CURSOR_CUENTA   = 25'd25000000,
  parameter logic [16:0] TONO_CUENTA     = 17'd50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fin_crono,
  input  logic       ack,
  input  logic       frame_tick,
  input  logic [7:0] progra_lugar,
  input  logic [2:0] dir_cursor,
  output logic       alarma_activa,
  output logic       invertir_color,
  output logic [5:0] mascara_campo,
  output logic       zumbador
);

  typedef enum logic {IDLE, ALARMA} estado_t;

  estado_t     estado, estado_sig;
  logic [23:0] contador, contador_sig;
  logic [5:0]  totalcont, totalcont_sig;
  logic        fase, fase_sig;
  logic        fin_prev;
  logic        subida;
  logic        salida;
  logic [24:0] cur_cont;
  logic        cur_fase;
  logic        programando;
  logic [5:0]  mascara_int;

  assign subida      = fin_crono & ~fin_prev;
  assign programando = |progra_lugar;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado    <= IDLE;
      contador  <= '0;
      totalcont <= '0;
      fase      <= 1'b0;
      fin_prev  <= 1'b0;
    end else begin
      estado    <= estado_sig;
      contador  <= contador_sig;
      totalcont <= totalcont_sig;
      fase      <= fase_sig;
      fin_prev  <= fin_crono;
    end
  end

  // The last off half-period runs to completion before the alarm ends,
  // so each flash is a full on/off pair; salida flags any return to IDLE.
  always_comb begin
    estado_sig    = estado;
    contador_sig  = contador;
    totalcont_sig = totalcont;
    fase_sig      = fase;
    salida        = 1'b0;
    case (estado)
      IDLE: begin
        if (subida) begin
          estado_sig    = ALARMA;
          contador_sig  = '0;
          totalcont_sig = '0;
          fase_sig      = 1'b1;
        end
      end
      ALARMA: begin
        if (subida) begin
          contador_sig  = '0;
          totalcont_sig = '0;
          fase_sig      = 1'b1;
        end else if (ack) begin
          estado_sig    = IDLE;
          contador_sig  = '0;
          totalcont_sig = '0;
          fase_sig      = 1'b0;
          salida        = 1'b1;
        end else if (contador == CUENTA - 24'd1) begin
          contador_sig = '0;
          if (fase) begin
            fase_sig      = 1'b0;
            totalcont_sig = totalcont + 6'd1;
          end else if (totalcont >= TOTAL_PARPADEOS) begin
            estado_sig    = IDLE;
            totalcont_sig = '0;
            salida        = 1'b1;
          end else begin
            fase_sig = 1'b1;
          end
        end else begin
          contador_sig = contador + 24'd1;
        end
      end
      default: estado_sig = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_cont <= '0;
      cur_fase <= 1'b1;
    end else if (!programando) begin
      cur_cont <= '0;
      cur_fase <= 1'b1;
    end else if (cur_cont == CURSOR_CUENTA - 25'd1) begin
      cur_cont <= '0;
      cur_fase <= ~cur_fase;
    end else begin
      cur_cont <= cur_cont + 25'd1;
    end
  end

  // Alarm takes priority over the cursor blank; out-of-range fields blank nothing.
  always_comb begin
    mascara_int = '0;
    if (programando && !cur_fase && (estado != ALARMA) && (dir_cursor < 3'd6))
      mascara_int = 6'b000001 << dir_cursor;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alarma_activa  <= 1'b0;
      invertir_color <= 1'b0;
      mascara_campo  <= '0;
    end else begin
      alarma_activa <= (estado == ALARMA);
      if (salida)
        invertir_color <= 1'b0;
      else if (frame_tick)
        invertir_color <= fase;
      if (frame_tick)
        mascara_campo <= mascara_int;
    end
  end

`ifdef ALARMA_SONIDO_EN
  logic [16:0] tono_cont;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tono_cont <= '0;
      zumbador  <= 1'b0;
    end else if ((estado == ALARMA) && fase) begin
      if (tono_cont == TONO_CUENTA - 17'd1) begin
        tono_cont <= '0;
        zumbador  <= ~zumbador;
      end else begin
        tono_cont <= tono_cont + 17'd1;
      end
    end else begin
      tono_cont <= '0;
      zumbador  <= 1'b0;
    end
  end
`else
  logic unused_tono;
  assign unused_tono = ^TONO_CUENTA;
  assign zumbador    = 1'b0;
`endif

endmodule

// File: tb/tb_vga_parpadeo_ctrl.sv
// Scoreboard bench for vga_parpadeo_ctrl with CUENTA=4, TOTAL_PARPADEOS=3, CURSOR_CUENTA=5, TONO_CUENTA=1.
module tb_vga_parpadeo_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       fin_crono;
  logic       ack;
  logic       frame_tick;
  logic [7:0] progra_lugar;
  logic [2:0] dir_cursor;
  logic       alarma_activa;
  logic       invertir_color;
  logic [5:0] mascara_campo;
  logic       zumbador;

`ifdef ALARMA_SONIDO_EN
  localparam bit SONIDO = 1'b1;
`else
  localparam bit SONIDO = 1'b0;
`endif

  typedef struct {
    string      name;
    logic       a;
    logic       i;
    logic [5:0] m;
    logic       z;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  vga_parpadeo_ctrl #(
    .CUENTA          (24'd4),
    .TOTAL_PARPADEOS (6'd3),
    .CURSOR_CUENTA   (25'd5),
    .TONO_CUENTA     (17'd1)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .fin_crono      (fin_crono),
    .ack            (ack),
    .frame_tick     (frame_tick),
    .progra_lugar   (progra_lugar),
    .dir_cursor     (dir_cursor),
    .alarma_activa  (alarma_activa),
    .invertir_color (invertir_color),
    .mascara_campo  (mascara_campo),
    .zumbador       (zumbador)
  );

  always #5 clk = ~clk;

  // Flash phase n edges after the alarm starts: 4 on, 4 off, three times.
  function automatic logic on_base(input int n);
    return (n >= 1) && (n <= 24) && (((n - 1) % 8) < 4);
  endfunction

  // With TONO_CUENTA=1 the buzzer toggles every edge of an on-phase, starting high.
  function automatic logic zum_base(input int n);
    return SONIDO && on_base(n) && ((n % 2) == 1);
  endfunction

  task automatic compare(input string nm, input logic [5:0] act, input logic [5:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      compare({e.name, "/alarma_activa"}, {5'd0, alarma_activa}, {5'd0, e.a});
      compare({e.name, "/invertir_color"}, {5'd0, invertir_color}, {5'd0, e.i});
      compare({e.name, "/mascara_campo"}, mascara_campo, e.m);
      compare({e.name, "/zumbador"}, {5'd0, zumbador}, {5'd0, e.z});
    end
  end

  task automatic checkOutput(input string nm, input logic a, input logic i,
                             input logic [5:0] m, input logic z);
    exp_t e;
    e.name = nm;
    e.a    = a;
    e.i    = i;
    e.m    = m;
    e.z    = z;
    exp_q.push_back(e);
  endtask

  task automatic applyStimulus(input logic fc, input logic ak, input logic ft,
                               input logic [7:0] pl, input logic [2:0] dc);
    @(negedge clk);
    fin_crono    = fc;
    ack          = ak;
    frame_tick   = ft;
    progra_lugar = pl;
    dir_cursor   = dc;
    @(posedge clk);
  endtask

  task automatic runFullAlarm(input string nm, input logic [7:0] pl, input logic [2:0] dc,
                              input int nsteps);
    for (int k = 0; k < nsteps; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, pl, dc);
      checkOutput(nm, (k >= 1) && (k <= 24), on_base(k), 6'd0, zum_base(k));
    end
  endtask

  task automatic idleStep(input string nm, input logic ft);
    applyStimulus(1'b0, 1'b0, ft, 8'd0, 3'd0);
    checkOutput(nm, 1'b0, 1'b0, 6'd0, 1'b0);
  endtask

  initial begin
    rst          = 1'b1;
    fin_crono    = 1'b0;
    ack          = 1'b0;
    frame_tick   = 1'b0;
    progra_lugar = 8'd0;
    dir_cursor   = 3'd0;
    #1 checkOutput("reset", 1'b0, 1'b0, 6'd0, 1'b0);
    @(negedge clk);
    #1 rst = 1'b0;

    for (int k = 0; k < 50; k++) idleStep("idle", 1'b0);

    runFullAlarm("alarm", 8'd0, 3'd0, 36);
    idleStep("alarm_end", 1'b1);

    for (int k = 0; k <= 14; k++) begin
      applyStimulus(1'b1, (k == 10), 1'b1, 8'd0, 3'd0);
      checkOutput("ack", (k >= 1) && (k <= 10), (k <= 9) && on_base(k), 6'd0,
                  (k <= 10) && zum_base(k));
    end
    idleStep("ack_end", 1'b1);
    runFullAlarm("restart", 8'd0, 3'd0, 26);
    idleStep("restart_end", 1'b1);

    for (int k = 0; k <= 32; k++) begin
      int n;
      n = (k <= 6) ? k : k - 6;
      applyStimulus((k != 5), (k == 6), 1'b1, 8'd0, 3'd0);
      checkOutput("rise_over_ack", (k >= 1) && (k <= 30), on_base(n), 6'd0, zum_base(n));
    end
    idleStep("rise_end", 1'b1);

    for (int k = 0; k <= 37; k++) begin
      logic [2:0] dc;
      logic [7:0] pl;
      dc = ((k >= 20) && (k < 30)) ? 3'd7 : 3'd3;
      pl = (k >= 35) ? 8'h00 : 8'h02;
      applyStimulus(1'b0, 1'b0, 1'b1, pl, dc);
      checkOutput("cursor", 1'b0, 1'b0,
                  ((k < 35) && (dc == 3'd3) && (((k / 5) % 2) == 1)) ? 6'b001000 : 6'd0, 1'b0);
    end
    for (int k = 0; k < 20; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 8'h02, 3'd3);
      checkOutput("cursor_restart", 1'b0, 1'b0,
                  (((k / 5) % 2) == 1) ? 6'b001000 : 6'd0, 1'b0);
    end
    for (int k = 0; k < 3; k++) idleStep("cursor_off", 1'b1);

    runFullAlarm("priority", 8'h02, 3'd0, 25);
    for (int k = 0; k < 3; k++) idleStep("priority_end", 1'b1);

    for (int k = 0; k <= 27; k++) begin
      applyStimulus(1'b1, 1'b0, ((k % 10) == 3), 8'd0, 3'd0);
      checkOutput("sparse_tick", (k >= 1) && (k <= 24), (k >= 3) && (k <= 12), 6'd0, zum_base(k));
    end
    idleStep("sparse_end", 1'b0);

    for (int k = 0; k <= 12; k++) begin
      applyStimulus(1'b1, (k == 7), (k == 3), 8'd0, 3'd0);
      checkOutput("sparse_ack", (k >= 1) && (k <= 7), (k >= 3) && (k <= 6), 6'd0,
                  (k <= 7) && zum_base(k));
    end
    idleStep("sparse_ack_end", 1'b0);

    for (int k = 0; k <= 1; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 8'd0, 3'd0);
      checkOutput("pre_reset", (k >= 1), on_base(k), 6'd0, zum_base(k));
    end
    applyStimulus(1'b1, 1'b0, 1'b1, 8'd0, 3'd0);
    #2;
    rst       = 1'b1;
    fin_crono = 1'b0;
    checkOutput("async_reset", 1'b0, 1'b0, 6'd0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) idleStep("post_reset", 1'b1);

    @(negedge clk);
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
